// File: rtl/interrupt_scheduler_custom_instruction.sv
// Custom-instruction interrupt scheduler: waits for one eligible pending source,
// grants it round-robin, or reports a timeout or a bad request.
module interrupt_scheduler_custom_instruction #(
  parameter int N_SRC = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clk_en,
  input  logic             start,
  input  logic [31:0]      dataa,
  input  logic [31:0]      datab,
  input  logic [N_SRC-1:0] irq,
  output logic [31:0]      result,
  output logic             done,
  output logic [N_SRC-1:0] pending
);

  // state  | meaning
  // S_IDLE | waiting for a start strobe
  // S_WAIT | searching pending & mask each cycle, counting down the timeout
  // S_DONE | done and result valid for this single cycle
  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

  state_t           state_q, state_d;
  logic [N_SRC-1:0] pending_q, pending_d;
  logic [N_SRC-1:0] irq_q;
  logic [N_SRC-1:0] mask_q, mask_d;
  logic [31:0]      cnt_q, cnt_d;
  logic [2:0]       rr_q, rr_d;
  logic             done_q, done_d;
  logic [31:0]      result_q, result_d;

  logic [N_SRC-1:0] eligible;
  logic [N_SRC-1:0] grant_oh;
  logic             grant;
  logic             found;
  logic [2:0]       gnt_id;
  int               gnt_i;
  logic             unused_dataa;

  assign unused_dataa = ^dataa[31:N_SRC];
  assign eligible     = pending_q & mask_q;

  // Round-robin pick: the eligible source closest to rr_q going upward.
  always_comb begin
    int d;
    int best_d;
    best_d = N_SRC;
    gnt_i  = 0;
    for (int j = 0; j < N_SRC; j++) begin
      d = (j >= int'(rr_q)) ? (j - int'(rr_q)) : (j + N_SRC - int'(rr_q));
      if (eligible[j] && (d < best_d)) begin
        best_d = d;
        gnt_i  = j;
      end
    end
    found  = (best_d < N_SRC);
    gnt_id = 3'(gnt_i);
  end

  assign grant = clk_en && (state_q == S_WAIT) && found;

  always_comb begin
    for (int j = 0; j < N_SRC; j++) begin
      grant_oh[j] = grant && (j == gnt_i);
    end
  end

  always_comb begin
    state_d  = state_q;
    mask_d   = mask_q;
    cnt_d    = cnt_q;
    rr_d     = rr_q;
    done_d   = 1'b0;
    result_d = 32'h0;
    // A new rising edge wins over the clear from a grant in the same cycle.
    pending_d = (pending_q & ~grant_oh) | (irq & ~irq_q);

    if (!clk_en) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            mask_d = dataa[N_SRC-1:0];
            cnt_d  = datab;
            if ((dataa[N_SRC-1:0] == '0) && (datab == 32'h0)) begin
              state_d      = S_DONE;
              done_d       = 1'b1;
              result_d[30] = 1'b1;
            end else begin
              state_d = S_WAIT;
            end
          end
        end
        S_WAIT: begin
          if (grant) begin
            rr_d          = (gnt_i == N_SRC - 1) ? 3'd0 : 3'(gnt_i + 1);
            state_d       = S_DONE;
            done_d        = 1'b1;
            result_d[8]   = 1'b1;
            result_d[2:0] = gnt_id;
          end else if (cnt_q != 32'h0) begin
            cnt_d = cnt_q - 32'd1;
            if (cnt_q == 32'd1) begin
              state_d      = S_DONE;
              done_d       = 1'b1;
              result_d[31] = 1'b1;
            end
          end
        end
        S_DONE: begin
          state_d = S_IDLE;
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      pending_q <= '0;
      irq_q     <= '0;
      mask_q    <= '0;
      cnt_q     <= 32'h0;
      rr_q      <= 3'd0;
      done_q    <= 1'b0;
      result_q  <= 32'h0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      irq_q     <= irq;
      mask_q    <= mask_d;
      cnt_q     <= cnt_d;
      rr_q      <= rr_d;
      done_q    <= done_d;
      result_q  <= result_d;
    end
  end

  assign result  = result_q;
  assign done    = done_q;
  assign pending = pending_q;

endmodule

// File: tb/tb_interrupt_scheduler_custom_instruction.sv
// Self-checking bench: directed scenarios plus randomized instructions checked
// against a queue-free behavioural model of pending bits and round-robin order.
module tb_interrupt_scheduler_custom_instruction;
  localparam int N = 8;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          clk_en = 1'b0;
  logic          start = 1'b0;
  logic [31:0]   dataa = 32'h0;
  logic [31:0]   datab = 32'h0;
  logic [N-1:0]  irq = '0;
  logic [31:0]   result;
  logic          done;
  logic [N-1:0]  pending;

  int checks = 0;
  int failures = 0;

  logic [N-1:0] m_pend = '0;
  logic [N-1:0] m_prev = '0;
  int           m_rr = 0;

  interrupt_scheduler_custom_instruction #(.N_SRC(N)) dut (
    .clk(clk), .reset(reset), .clk_en(clk_en), .start(start),
    .dataa(dataa), .datab(datab), .irq(irq),
    .result(result), .done(done), .pending(pending)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_irq(input logic [N-1:0] v);
    irq    = v;
    m_pend = m_pend | (v & ~m_prev);
    m_prev = v;
  endtask

  function automatic int pick(input logic [N-1:0] e);
    for (int i = 0; i < N; i++) begin
      if (e[(m_rr + i) % N]) return (m_rr + i) % N;
    end
    return -1;
  endfunction

  // Issues one instruction with irq held steady; the caller never requests an endless wait.
  task automatic do_instr(input logic [31:0] a, input logic [31:0] b, input string tag);
    logic [N-1:0] elig;
    logic [31:0]  exp_res;
    int exp_lat;
    int lat;
    int k;
    elig = m_pend & a[N-1:0];
    if (elig != '0) begin
      k       = pick(elig);
      exp_res = 32'h100 | 32'(k);
      exp_lat = 2;
      m_pend[k] = 1'b0;
      m_rr    = (k + 1) % N;
    end else if ((a[N-1:0] == '0) && (b == 32'h0)) begin
      exp_res = 32'h4000_0000;
      exp_lat = 1;
    end else begin
      exp_res = 32'h8000_0000;
      exp_lat = int'(b) + 1;
    end
    clk_en = 1'b1;
    dataa  = a;
    datab  = b;
    start  = 1'b1;
    step();
    start = 1'b0;
    lat   = 1;
    while ((done !== 1'b1) && (lat < exp_lat + 5)) begin
      step();
      lat++;
    end
    chk({tag, "_lat"}, 32'(lat), 32'(exp_lat));
    chk({tag, "_res"}, result, exp_res);
    step();
    chk({tag, "_done_drop"}, {31'h0, done}, 32'h0);
    chk({tag, "_res_clr"}, result, 32'h0);
    chk({tag, "_pend"}, 32'(pending), 32'(m_pend));
  endtask

  initial begin
    logic [31:0] a;
    logic [31:0] b;
    reset = 1'b0;
    repeat (3) step();
    chk("rst_done", {31'h0, done}, 32'h0);
    chk("rst_result", result, 32'h0);
    chk("rst_pend", 32'(pending), 32'h0);
    reset  = 1'b1;
    clk_en = 1'b1;
    step();

    // Round-robin order from rr=0
    set_irq(8'h11); step(); set_irq(8'h00); step();
    chk("rr_pend", 32'(pending), 32'h11);
    do_instr(32'hFF, 32'h0, "rr_first");
    do_instr(32'hFF, 32'h0, "rr_second");

    // Fixed-latency grant
    set_irq(8'h08); step(); set_irq(8'h00); step();
    do_instr(32'hFF, 32'h0, "fixed");

    do_instr(32'h01, 32'd5, "timeout");
    do_instr(32'h00, 32'h0, "bad_req");

    // Masked pending[2]; irq[0] becomes pending in the expiry cycle, grant wins
    set_irq(8'h04); step(); set_irq(8'h00); step();
    dataa = 32'h01; datab = 32'd3; start = 1'b1;
    step();
    start = 1'b0;
    step();
    set_irq(8'h01);
    step();
    set_irq(8'h00);
    step();
    chk("coll_done", {31'h0, done}, 32'h1);
    chk("coll_res", result, 32'h100);
    m_pend[0] = 1'b0;
    m_rr = 1;
    step();
    chk("coll_pend", 32'(pending), 32'(m_pend));

    // Abort: clk_en drops in the cycle a grant would happen
    dataa = 32'h04; datab = 32'h0; start = 1'b1;
    step();
    start = 1'b0; clk_en = 1'b0;
    step();
    clk_en = 1'b1;
    chk("abort_done0", {31'h0, done}, 32'h0);
    step();
    chk("abort_done1", {31'h0, done}, 32'h0);
    chk("abort_pend", 32'(pending), 32'h04);
    do_instr(32'h04, 32'h0, "post_abort");

    // Reset while an operation is in flight
    set_irq(8'h41); step(); set_irq(8'h00); step();
    dataa = 32'h01; datab = 32'h0; start = 1'b1;
    step();
    start = 1'b0;
    step();
    chk("inflight_done", {31'h0, done}, 32'h1);
    reset = 1'b0;
    #1;
    chk("rst_mid_done", {31'h0, done}, 32'h0);
    chk("rst_mid_res", result, 32'h0);
    chk("rst_mid_pend", 32'(pending), 32'h0);
    m_pend = '0; m_prev = '0; m_rr = 0;
    step(); step();
    reset = 1'b1;
    step();

    for (int it = 0; it < 40; it++) begin
      int ncyc;
      ncyc = int'($urandom_range(1, 3));
      for (int c = 0; c < ncyc; c++) begin
        set_irq(N'($urandom));
        step();
      end
      a = (it % 5 == 0) ? 32'h0 : $urandom;
      if ((m_pend & a[N-1:0]) != '0) b = $urandom_range(0, 8);
      else if (a[N-1:0] == '0) b = $urandom_range(0, 6);
      else b = $urandom_range(1, 8);
      do_instr(a, b, "rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/interrupt_scheduler_custom_instruction.md
INTERRUPT_SCHEDULER_CUSTOM_INSTRUCTION -- requirements
Module: interrupt_scheduler_custom_instruction

Interface
REQ-001 SHALL have parameter N_SRC, default 8, meaning the number of interrupt sources (supported range 2..8).
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all flops are rising-edge.
REQ-003 SHALL have port reset, input, 1 bit: the reset, asynchronous and active-low.
REQ-004 SHALL have port clk_en, input, 1 bit: custom-instruction enable; low aborts any operation.
REQ-005 SHALL have port start, input, 1 bit: custom-instruction start strobe, sampled when clk_en is high.
REQ-006 SHALL have port dataa, input, 32 bits: [N_SRC-1:0] is the source enable mask; the other bits are ignored.
REQ-007 SHALL have port datab, input, 32 bits: timeout in clk cycles; 0 means no timeout.
REQ-008 SHALL have port irq, input, N_SRC bits: level interrupt lines, synchronous to clk.
REQ-009 SHALL have port result, output, 32 bits: completion word, defined in REQ-020.
REQ-010 SHALL have port done, output, 1 bit: one-cycle completion pulse.
REQ-011 SHALL have port pending, output, N_SRC bits: current pending latches, for debug.

Function
REQ-012 SHALL register irq each cycle as irq_q and set pending[i] on every rising edge (irq[i] & ~irq_q[i]), in every state.
REQ-013 SHALL retain pending bits across instructions until each bit is granted; no other event clears them.
REQ-014 SHALL implement states IDLE, WAIT and DONE.
REQ-015 SHALL, in IDLE with clk_en=1 and start=1, latch the mask and load the timeout counter with datab.
- Normal request: next state is WAIT.
- Mask=0 and datab=0: next state is DONE with the bad-request flag set.
REQ-016 SHALL, in WAIT, evaluate eligible = pending & mask every cycle.
- Eligible nonzero: grant one source by round-robin, clear its pending bit, go to DONE.
REQ-017 SHALL run the round-robin search from pointer rr upward, wrapping modulo N_SRC; after a grant of source k, rr = (k+1) mod N_SRC; rr resets to 0.
REQ-018 SHALL, in WAIT with a nonzero timeout and no grant, decrement the counter.
- Counter decrements 1 -> 0 without a grant: go to DONE with the timeout flag set.
- Grant and expiry in the same cycle: the grant wins and the timeout flag stays 0.
REQ-019 SHALL keep pending[k] set if a new rising edge on irq[k] arrives in the same cycle that k is granted (set wins over clear).
REQ-020 SHALL assert done=1 for exactly one cycle in DONE, then return to IDLE. result is driven only in that cycle, else 0x00000000:
- [31] timeout
- [30] bad request
- [8] grant valid
- [2:0] granted source id
- all other bits 0
REQ-021 SHALL give a latency of 2 cycles from start to done when an eligible bit is already pending: start in cycle T, grant in T+1, done in T+2.
REQ-022 SHALL, whenever clk_en=0, force state to IDLE and done=0 on the next edge; pending and rr are unaffected and no grant occurs.
REQ-023 SHALL ignore start while not in IDLE.

Reset
REQ-024 SHALL, while reset=0, asynchronously clear state to IDLE, done, result, pending, irq_q, rr, the mask register and the timeout counter.
REQ-025 SHALL discard any in-flight operation on reset; the first instruction after reset release behaves as if no interrupt had ever occurred.

Verification
REQ-026 Fixed-latency grant: pulse irq[3], then start with dataa=0xFF, datab=0 -> done at T+2, result=0x00000103, pending[3]=0.
REQ-027 Round-robin order: pending=0x11, rr=0, two back-to-back instructions with mask 0xFF -> results 0x100 then 0x104; rr ends at 5.
REQ-028 Timeout: no irq, dataa=0x01, datab=5 -> done exactly 6 cycles after start, result=0x80000000.
REQ-029 Bad request: dataa=0, datab=0 -> done at T+1, result=0x40000000.
REQ-030 Masking and collision: pending[2] set, mask 0x01, then irq[0] edge coincident with counter expiry -> result=0x00000100, pending[2] remains 1.
REQ-031 Abort and reset: clk_en dropped in WAIT -> IDLE with no done and pending unchanged; reset asserted mid-WAIT -> all outputs 0 immediately.
